// File: rtl/cam_pkg.sv
// Shared types for the camera power sequencer: state encoding, counter width and
// the per-state pin decode.
package cam_pkg;

  localparam int unsigned CntW = 24;

  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [2:0] {
    StOff       = 3'd0,
    StWakePwdn  = 3'd1,
    StWakeRst   = 3'd2,
    StOn        = 3'd3,
    StDownDrain = 3'd4,
    StDownRst   = 3'd5
  } state_e;

  typedef struct packed {
    logic pwdn;
    logic reset_n;
    logic en;
    logic busy;
  } pins_t;

  localparam pins_t PinsOff = '{pwdn: 1'b1, reset_n: 1'b0, en: 1'b0, busy: 1'b0};

  function automatic pins_t state_pins(state_e s);
    pins_t p;
    case (s)
      StWakePwdn:  p = '{pwdn: 1'b0, reset_n: 1'b0, en: 1'b0, busy: 1'b1};
      StWakeRst:   p = '{pwdn: 1'b0, reset_n: 1'b1, en: 1'b0, busy: 1'b1};
      StOn:        p = '{pwdn: 1'b0, reset_n: 1'b1, en: 1'b1, busy: 1'b0};
      StDownDrain: p = '{pwdn: 1'b0, reset_n: 1'b1, en: 1'b0, busy: 1'b1};
      StDownRst:   p = '{pwdn: 1'b0, reset_n: 1'b0, en: 1'b0, busy: 1'b1};
      default:     p = PinsOff;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cam_power_seq_if.sv
// Request/status bundle between a power controller (master) and the camera
// power sequencer (slave).
interface cam_power_seq_if;
  logic pwr_up_req;
  logic pwr_dn_req;
  logic cam_pwdn;
  logic cam_reset_n;
  logic path_en;
  logic busy;
  logic done;

  modport master (
    output pwr_up_req,
    output pwr_dn_req,
    input  cam_pwdn,
    input  cam_reset_n,
    input  path_en,
    input  busy,
    input  done
  );

  modport slave (
    input  pwr_up_req,
    input  pwr_dn_req,
    output cam_pwdn,
    output cam_reset_n,
    output path_en,
    output busy,
    output done
  );
endinterface

// File: rtl/cam_power_seq.sv
// Camera power-up/power-down sequencer: timed PWDN/RESET phases sharing one
// down-counter, with all pin outputs registered from the next state.
module cam_power_seq
  import cam_pkg::*;
#(
  parameter cnt_t T_SETTLE = 24'd5000,
  parameter cnt_t T_RST    = 24'd1000,
  parameter cnt_t T_DRAIN  = 24'd500
) (
  input  logic             clk_50,
  input  logic             rst_n,
  cam_power_seq_if.slave   bus
);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  pins_t  pins_q, pins_d;
  logic   done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        if (bus.pwr_up_req) begin
          state_d = StWakePwdn;
          cnt_d   = T_SETTLE - cnt_t'(1);
        end
      end
      StWakePwdn: begin
        if (cnt_q == '0) begin
          state_d = StWakeRst;
          cnt_d   = T_RST - cnt_t'(1);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StWakeRst: begin
        if (cnt_q == '0) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StOn: begin
        if (bus.pwr_dn_req) begin
          state_d = StDownDrain;
          cnt_d   = T_DRAIN - cnt_t'(1);
        end
      end
      StDownDrain: begin
        if (cnt_q == '0) begin
          state_d = StDownRst;
          cnt_d   = T_RST - cnt_t'(1);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StDownRst: begin
        if (cnt_q == '0) begin
          state_d = StOff;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoding the next state lets the pins change on the same edge as the state.
  always_comb begin
    pins_d = state_pins(state_d);
    done_d = (state_d != state_q) && ((state_d == StOn) || (state_d == StOff));
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      pins_q  <= PinsOff;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
      done_q  <= done_d;
    end
  end

  assign bus.cam_pwdn    = pins_q.pwdn;
  assign bus.cam_reset_n = pins_q.reset_n;
  assign bus.path_en     = pins_q.en;
  assign bus.busy        = pins_q.busy;
  assign bus.done        = done_q;

endmodule

// File: doc/cam_power_seq.md
CAM_POWER_SEQ -- requirements
Module: cam_power_seq

Interface
REQ-001 Parameter T_SETTLE, default 24'd5000: cycles spent in WAKE_PWDN, power-down released and reset held; legal range 1..2^24-1.
REQ-002 Parameter T_RST, default 24'd1000: cycles spent in each reset phase (WAKE_RST, DOWN_RST); legal range 1..2^24-1.
REQ-003 Parameter T_DRAIN, default 24'd500: cycles spent in DOWN_DRAIN, data path disabled before reset; legal range 1..2^24-1.
REQ-004 clk_50  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pwr_up_req  input  1  request power-up; single-cycle pulse or level.
REQ-007 pwr_dn_req  input  1  request power-down; single-cycle pulse or level.
REQ-008 cam_pwdn  output  1  camera PWDN pin; 1 = powered down.
REQ-009 cam_reset_n  output  1  camera RESET pin; active low.
REQ-010 path_en  output  1  enable for capture/SCCB data path; 1 = camera usable.
REQ-011 busy  output  1  high while a sequence is in progress.
REQ-012 done  output  1  one-cycle pulse on entering ON or OFF.

Function
REQ-013 FSM states: OFF, WAKE_PWDN, WAKE_RST, ON, DOWN_DRAIN, DOWN_RST.
REQ-014 Output decode, registered: OFF pwdn=1/reset_n=0/en=0; WAKE_PWDN 0/0/0; WAKE_RST 0/1/0; ON 0/1/1; DOWN_DRAIN 0/1/0; DOWN_RST 0/0/0.
REQ-015 busy=1 exactly in WAKE_PWDN, WAKE_RST, DOWN_DRAIN, DOWN_RST.
REQ-016 OFF: pwr_up_req=1 at an edge -> WAKE_PWDN on that edge; pwr_dn_req ignored.
REQ-017 ON: pwr_dn_req=1 at an edge -> DOWN_DRAIN on that edge; pwr_up_req ignored.
REQ-018 Each timed state lasts exactly its parameter count of cycles; transitions: WAKE_PWDN->WAKE_RST->ON, DOWN_DRAIN->DOWN_RST->OFF.
REQ-019 Both requests ignored in timed states; no queuing; a request still high on reaching ON/OFF is evaluated normally on the next edge.
REQ-020 Simultaneous pwr_up_req and pwr_dn_req: only the one relevant to current state (REQ-016/017) acts.
REQ-021 A level request held high therefore causes no repeat: in OFF, held pwr_up_req leads to ON and stays; held pwr_dn_req alone never leaves OFF.
REQ-022 Single shared 24-bit down-counter loaded with (param-1) on entering a timed state; state advances when counter is 0; no wrap-around.
REQ-023 done=1 for exactly one cycle, the first cycle in ON or in OFF after a sequence; not asserted after reset.
REQ-024 Latency: request edge k -> path_en rises at edge k+T_SETTLE+T_RST; pwr_dn edge k -> path_en falls at edge k, cam_pwdn rises at edge k+T_DRAIN+T_RST.
REQ-025 path_en is never 1 unless cam_pwdn=0 and cam_reset_n=1 in the same cycle.

Reset
REQ-026 rst_n low asynchronously forces state OFF, counter 0, cam_pwdn=1, cam_reset_n=0, path_en=0, busy=0, done=0.
REQ-027 Reset mid-sequence aborts immediately to OFF values; no done pulse.
REQ-028 After rst_n rises, first request is sampled at the next rising edge.

Structure
REQ-029 State encoding and the counter width constant (24) SHALL live in a shared package cam_pkg.
REQ-030 Single flat module; no sub-module; outputs driven from flops, no clock gating.

Verification (T_SETTLE=4, T_RST=3, T_DRAIN=2)
REQ-031 Reset release, no requests for 20 cycles -> pwdn=1, reset_n=0, en=0, busy=0, done never 1.
REQ-032 pwr_up_req pulse at edge 0 -> pwdn=0 from edge 0, reset_n=1 from edge 4, en=1 and done=1 at edge 7, done=0 at edge 8, busy high edges 0..6.
REQ-033 From ON, pwr_dn_req pulse at edge 0 -> en=0 edge 0, reset_n=0 edge 2, pwdn=1 and done=1 edge 5.
REQ-034 pwr_dn_req pulsed during WAKE_RST and pwr_up_req pulsed during DOWN_DRAIN -> both ignored, sequence timing unchanged.
REQ-035 rst_n driven low mid-WAKE_RST (between edges) -> outputs reach OFF values without waiting for clock; done stays 0.
REQ-036 Both requests held high from OFF -> reaches ON at edge 7, then immediately runs power-down, OFF at edge 13, then powers up again (continuous cycling, checked for 3 iterations).
